// File: rtl/dma_read_splitter.sv
// dma_read_splitter: accepts a byte-range read request, breaks it into DMA
// read commands that never cross a MAX_BURST boundary, caps the number of
// commands whose data is still in flight, and forwards the returning data
// stream downstream with a request-level last flag.
//
// Handshake rule for every channel: a transfer happens on a rising edge
// where valid and ready are both 1; a source holding valid does not change
// its payload until that transfer happens.
module dma_read_splitter #(
    parameter int WIDTH           = 512,
    parameter int MAX_BURST       = 4096,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [63:0]        req_address,
    input  logic [31:0]        req_length,
    output logic               read_cmd_valid,
    input  logic               read_cmd_ready,
    output logic [63:0]        read_cmd_address,
    output logic [31:0]        read_cmd_length,
    input  logic               read_data_valid,
    input  logic [WIDTH-1:0]   read_data_data,
    input  logic [WIDTH/8-1:0] read_data_keep,
    input  logic               read_data_last,
    output logic               read_data_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               done,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int BEAT_BYTES = WIDTH / 8;
    localparam int BEAT_LOG2  = $clog2(BEAT_BYTES);
    localparam int BURST_LOG2 = $clog2(MAX_BURST);
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT_C   = OW'(MAX_OUTSTANDING);
    localparam logic [31:0]   MAX_BURST_C = 32'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    cur_addr_q, cur_addr_d;
    logic [31:0]    remaining_q, remaining_d;
    logic [31:0]    beats_left_q, beats_left_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;

    logic [31:0]    burst_space;
    logic [31:0]    cmd_len;
    logic           cmd_fire;
    logic           data_fire;
    logic           last_fire;

    // Keep strobes carry no information for this block.
    logic           unused_keep;
    assign unused_keep = ^read_data_keep;

    // Bytes left before the next MAX_BURST boundary; the command is clipped to it.
    assign burst_space = MAX_BURST_C - 32'(cur_addr_q[BURST_LOG2-1:0]);
    assign cmd_len     = (remaining_q < burst_space) ? remaining_q : burst_space;

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign read_cmd_valid   = (state_q == SPLIT) && (outstanding_q < MAX_OUT_C);
    assign read_cmd_address = cur_addr_q;
    assign read_cmd_length  = cmd_len;
    assign done             = (state_q == DRAIN) && (outstanding_q == '0) && (beats_left_q == '0);
    assign dbg_state        = state_q;

    // Data path is a straight wire; beats seen while idle are not counted.
    assign out_valid       = read_data_valid;
    assign out_data        = read_data_data;
    assign read_data_ready = out_ready;
    assign out_last        = read_data_valid && (beats_left_q == 32'd1);

    assign cmd_fire  = read_cmd_valid && read_cmd_ready;
    assign data_fire = read_data_valid && out_ready && (state_q != IDLE);
    assign last_fire = data_fire && read_data_last;

    // Next-state logic: request latch, command address/length walk, completion.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_d  = req_address;
                    remaining_d = req_length;
                    state_d     = (req_length != 32'd0) ? SPLIT : DRAIN;
                end
            end
            SPLIT: begin
                if (cmd_fire) begin
                    cur_addr_d  = cur_addr_q + 64'(cmd_len);
                    remaining_d = remaining_q - cmd_len;
                    if (remaining_q == cmd_len) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat and in-flight command counters.
    always_comb begin
        beats_left_d  = beats_left_q;
        outstanding_d = outstanding_q;
        if ((state_q == IDLE) && req_valid) begin
            beats_left_d = req_length >> BEAT_LOG2;
        end else if (data_fire && (beats_left_q != 32'd0)) begin
            beats_left_d = beats_left_q - 32'd1;
        end
        case ({cmd_fire, last_fire && (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            beats_left_q  <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            beats_left_q  <= beats_left_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_dma_read_splitter.sv
module tb_dma_read_splitter;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [63:0]  req_address;
    logic [31:0]  req_length;
    logic         read_cmd_valid, read_cmd_ready;
    logic [63:0]  read_cmd_address;
    logic [31:0]  read_cmd_length;
    logic         read_data_valid, read_data_last, read_data_ready;
    logic [511:0] read_data_data;
    logic [63:0]  read_data_keep;
    logic         out_valid, out_last, out_ready;
    logic [511:0] out_data;
    logic         done, busy;
    logic [1:0]   dbg_state;

    // second instance with a tight outstanding limit
    logic         req_valid2, req_ready2;
    logic         read_cmd_valid2, read_cmd_ready2;
    logic [63:0]  read_cmd_address2;
    logic [31:0]  read_cmd_length2;
    logic         read_data_valid2, read_data_last2, read_data_ready2;
    logic         out_valid2, out_last2, out_ready2;
    logic [511:0] out_data2;
    logic         done2, busy2;
    logic [1:0]   dbg_state2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    dma_read_splitter u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_length(req_length),
        .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
        .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
        .read_data_valid(read_data_valid), .read_data_data(read_data_data),
        .read_data_keep(read_data_keep), .read_data_last(read_data_last),
        .read_data_ready(read_data_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .done(done), .busy(busy), .dbg_state(dbg_state)
    );

    dma_read_splitter #(.MAX_OUTSTANDING(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_address(req_address), .req_length(req_length),
        .read_cmd_valid(read_cmd_valid2), .read_cmd_ready(read_cmd_ready2),
        .read_cmd_address(read_cmd_address2), .read_cmd_length(read_cmd_length2),
        .read_data_valid(read_data_valid2), .read_data_data(read_data_data),
        .read_data_keep(read_data_keep), .read_data_last(read_data_last2),
        .read_data_ready(read_data_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2),
        .out_ready(out_ready2), .done(done2), .busy(busy2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [63:0] addr, input logic [31:0] len);
        req_valid   = 1'b1;
        req_address = addr;
        req_length  = len;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic set_beat(input int idx, input logic last);
        read_data_valid = 1'b1;
        read_data_last  = last;
        read_data_data  = {16{32'hA5A5_0000 + 32'(idx)}};
        #1;
    endtask

    initial begin
        logic [511:0] exp_data;
        reset = 1'b1;
        req_valid = 1'b0; req_address = '0; req_length = '0;
        read_cmd_ready = 1'b0;
        read_data_valid = 1'b1; read_data_last = 1'b1;
        read_data_data = {16{32'hDEAD_BEEF}};
        read_data_keep = '1;
        out_ready = 1'b1;
        req_valid2 = 1'b0; read_cmd_ready2 = 1'b0;
        read_data_valid2 = 1'b0; read_data_last2 = 1'b0; out_ready2 = 1'b0;
        #1;
        // ---- reset values and pass-through during reset
        chk("rst_cmd_valid", read_cmd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_addr", read_cmd_address, 0);
        chk("rst_cmd_len", read_cmd_length, 0);
        exp_data = {16{32'hDEAD_BEEF}};
        chk("rst_out_valid", out_valid, 1);
        chk("rst_out_data", out_data, exp_data);
        chk("rst_rd_ready", read_data_ready, 1);
        chk("rst_out_last", out_last, 0);
        tick();
        tick();
        reset = 1'b0;
        read_data_valid = 1'b0; read_data_last = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t1_req_ready", req_ready, 1);

        // ---- single command, 4 beats
        send_req(64'h0, 32'h100);
        chk("t1_busy", busy, 1);
        chk("t1_req_ready_busy", req_ready, 0);
        chk("t1_cmd_valid", read_cmd_valid, 1);
        chk("t1_cmd_addr", read_cmd_address, 64'h0);
        chk("t1_cmd_len", read_cmd_length, 32'h100);
        read_cmd_ready = 1'b1;
        tick();
        read_cmd_ready = 1'b0;
        #1;
        chk("t1_cmd_valid_after", read_cmd_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(i, i == 3);
            exp_data = {16{32'hA5A5_0000 + 32'(i)}};
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_data", out_data, exp_data);
            chk("t1_out_last", out_last, (i == 3));
            chk("t1_done_early", done, 0);
            tick();
        end
        read_data_valid = 1'b0; read_data_last = 1'b0;
        #1;
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_done_clear", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_req_ready", req_ready, 1);

        // ---- boundary crossing split
        send_req(64'hFC0, 32'h80);
        read_cmd_ready = 1'b1;
        #1;
        chk("t2_cmd0_valid", read_cmd_valid, 1);
        chk("t2_cmd0_addr", read_cmd_address, 64'hFC0);
        chk("t2_cmd0_len", read_cmd_length, 32'h40);
        tick();
        chk("t2_cmd1_valid", read_cmd_valid, 1);
        chk("t2_cmd1_addr", read_cmd_address, 64'h1000);
        chk("t2_cmd1_len", read_cmd_length, 32'h40);
        tick();
        read_cmd_ready = 1'b0;
        chk("t2_cmd_done", read_cmd_valid, 0);
        set_beat(10, 1'b1);
        chk("t2_beat0_last", out_last, 0);
        tick();
        set_beat(11, 1'b1);
        chk("t2_beat1_last", out_last, 1);
        tick();
        read_data_valid = 1'b0; read_data_last = 1'b0;
        #1;
        chk("t2_done", done, 1);
        tick();
        chk("t2_idle", busy, 0);

        // ---- toggling command ready, stable fields while stalled
        send_req(64'h0, 32'h3000);
        for (int c = 0; c < 3; c++) begin
            read_cmd_ready = 1'b0;
            #1;
            chk("t3_valid", read_cmd_valid, 1);
            chk("t3_addr", read_cmd_address, 64'(c) * 64'h1000);
            chk("t3_len", read_cmd_length, 32'h1000);
            tick();
            chk("t3_stall_valid", read_cmd_valid, 1);
            chk("t3_stall_addr", read_cmd_address, 64'(c) * 64'h1000);
            chk("t3_stall_len", read_cmd_length, 32'h1000);
            read_cmd_ready = 1'b1;
            tick();
        end
        read_cmd_ready = 1'b0;
        #1;
        chk("t3_cmd_done", read_cmd_valid, 0);
        for (int i = 0; i < 192; i++) begin
            set_beat(i, (i % 64) == 63);
            if (i == 0 || i == 63 || i == 190 || i == 191)
                chk("t3_out_last", out_last, (i == 191));
            if (i == 100)
                chk("t3_done_mid", done, 0);
            tick();
        end
        read_data_valid = 1'b0; read_data_last = 1'b0;
        #1;
        chk("t3_done", done, 1);
        tick();
        chk("t3_idle", busy, 0);

        // ---- stray beat while idle passes through, touches nothing
        set_beat(77, 1'b1);
        exp_data = {16{32'hA5A5_0000 + 32'd77}};
        chk("t4_idle_out_data", out_data, exp_data);
        chk("t4_idle_out_last", out_last, 0);
        tick();
        read_data_valid = 1'b0; read_data_last = 1'b0;

        // ---- zero-length request
        send_req(64'h40, 32'h0);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 1);
        chk("t5_cmd_valid", read_cmd_valid, 0);
        tick();
        chk("t5_done_clear", done, 0);
        chk("t5_busy_clear", busy, 0);
        chk("t5_cmd_valid_after", read_cmd_valid, 0);

        // ---- reset in the middle of a transfer
        send_req(64'h0, 32'h3000);
        read_cmd_ready = 1'b1;
        tick();
        read_cmd_ready = 1'b0;
        #1;
        chk("t6_mid_addr", read_cmd_address, 64'h1000);
        reset = 1'b1;
        #1;
        chk("t6_rst_cmd_valid", read_cmd_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_addr", read_cmd_address, 0);
        chk("t6_rst_len", read_cmd_length, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_req_ready", req_ready, 1);
        send_req(64'h0, 32'h40);
        read_cmd_ready = 1'b1;
        #1;
        chk("t6_cmd_addr", read_cmd_address, 64'h0);
        chk("t6_cmd_len", read_cmd_length, 32'h40);
        tick();
        read_cmd_ready = 1'b0;
        set_beat(5, 1'b1);
        chk("t6_out_last", out_last, 1);
        tick();
        read_data_valid = 1'b0; read_data_last = 1'b0;
        #1;
        chk("t6_done", done, 1);
        tick();
        chk("t6_idle", busy, 0);

        // ---- outstanding limit of 2 with a stalled downstream
        read_cmd_ready2 = 1'b1;
        req_valid2 = 1'b1; req_address = 64'h0; req_length = 32'h4000;
        tick();
        req_valid2 = 1'b0;
        chk("t7_cmd0_valid", read_cmd_valid2, 1);
        chk("t7_cmd0_addr", read_cmd_address2, 64'h0);
        tick();
        chk("t7_cmd1_valid", read_cmd_valid2, 1);
        chk("t7_cmd1_addr", read_cmd_address2, 64'h1000);
        tick();
        chk("t7_limit_valid", read_cmd_valid2, 0);
        tick();
        chk("t7_limit_hold", read_cmd_valid2, 0);
        chk("t7_busy", busy2, 1);
        out_ready2 = 1'b1; read_data_valid2 = 1'b1; read_data_last2 = 1'b1;
        tick();
        out_ready2 = 1'b0; read_data_valid2 = 1'b0; read_data_last2 = 1'b0;
        #1;
        chk("t7_cmd2_valid", read_cmd_valid2, 1);
        chk("t7_cmd2_addr", read_cmd_address2, 64'h2000);
        chk("t7_cmd2_len", read_cmd_length2, 32'h1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
